// File: rtl/systolic_result_streamer_if.sv
// Result-stream bus between systolic_result_streamer and its sink
// (output memory or DMA writer): valid/ready element with row/col tags.
interface systolic_result_streamer_if #(
    parameter int DW = 16,
    parameter int IW = 4
);
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready;
    logic [IW-1:0] out_row;
    logic [IW-1:0] out_col;
    logic          out_last;

    // Streamer side: drives the element, samples ready.
    modport master (
        output out_data, out_valid, out_row, out_col, out_last,
        input  out_ready
    );

    // Sink side.
    modport slave (
        input  out_data, out_valid, out_row, out_col, out_last,
        output out_ready
    );
endinterface

// File: rtl/systolic_result_streamer.sv
// systolic_result_streamer: captures the N x N result matrix on the rising
// edge of done and streams it row-major over a valid/ready bus.
// Optional macro RESULT_CLAMP_EN: clamps each streamed element to 0..255
// (zero-extended) for 8-bit pixel writeback; undefined = raw signed data.
module systolic_result_streamer #(
    parameter int N  = 10,
    parameter int DW = 16,
    parameter int IW = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        done,
    input  logic signed [DW-1:0]        A_result [0:N-1][0:N-1],
    systolic_result_streamer_if.master  out_if,
    output logic                        busy,
    output logic                        frame_done,
    output logic                        overrun
);

    typedef enum logic {S_IDLE, S_STREAM} state_t;

    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_t              r_state;
    state_t              w_state_next;
    logic [IW-1:0]       r_row, r_col;
    logic [IW-1:0]       w_row_next, w_col_next;
    logic                r_done_q;
    logic                r_frame_done, w_frame_done_next;
    logic                r_overrun, w_overrun_next;
    logic                w_capture;
    logic                w_done_rise;
    logic                w_streaming;
    logic                w_xfer;
    logic                w_at_last;
    logic signed [DW-1:0] w_elem;
    logic [DW-1:0]       w_read;

    // Frame buffer; contents are never reset, only overwritten on capture.
    logic signed [DW-1:0] r_buf [0:N-1][0:N-1];

    assign w_done_rise = done & ~r_done_q;
    assign w_streaming = (r_state == S_STREAM);
    assign w_xfer      = w_streaming & out_if.out_ready;
    assign w_at_last   = (r_row == LAST_IDX) && (r_col == LAST_IDX);

    // Control registers: FSM state, element indices, edge detector, flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_row        <= '0;
            r_col        <= '0;
            r_done_q     <= 1'b0;
            r_frame_done <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_row        <= w_row_next;
            r_col        <= w_col_next;
            r_done_q     <= done;
            r_frame_done <= w_frame_done_next;
            r_overrun    <= w_overrun_next;
        end
    end

    // Next-state logic: capture on done rise, advance indices per transfer,
    // chain straight into a new frame if done rises on the last transfer.
    always_comb begin
        w_state_next      = r_state;
        w_row_next        = r_row;
        w_col_next        = r_col;
        w_capture         = 1'b0;
        w_frame_done_next = 1'b0;
        w_overrun_next    = r_overrun;
        case (r_state)
            S_IDLE: begin
                if (w_done_rise) begin
                    w_capture    = 1'b1;
                    w_row_next   = '0;
                    w_col_next   = '0;
                    w_state_next = S_STREAM;
                end
            end
            S_STREAM: begin
                if (w_xfer && w_at_last) begin
                    w_frame_done_next = 1'b1;
                    w_row_next        = '0;
                    w_col_next        = '0;
                    if (w_done_rise) begin
                        w_capture = 1'b1;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end else begin
                    if (w_xfer) begin
                        if (r_col == LAST_IDX) begin
                            w_col_next = '0;
                            w_row_next = r_row + 1'b1;
                        end else begin
                            w_col_next = r_col + 1'b1;
                        end
                    end
                    // A frame arriving mid-stream is dropped, not buffered.
                    if (w_done_rise) begin
                        w_overrun_next = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Buffer capture, one register per matrix element.
    for (genvar gi = 0; gi < N; gi++) begin : g_row
        for (genvar gj = 0; gj < N; gj++) begin : g_col
            // Load element [gi][gj] when a frame is accepted.
            always_ff @(posedge clk) begin
                if (w_capture) begin
                    r_buf[gi][gj] <= A_result[gi][gj];
                end
            end
        end
    end

    assign w_elem = r_buf[r_row][r_col];

`ifdef RESULT_CLAMP_EN
    localparam logic signed [DW-1:0] CLAMP_MAX = DW'(255);

    // Saturate the element into 0..255 for 8-bit writeback.
    always_comb begin
        if (w_elem[DW-1]) begin
            w_read = '0;
        end else if (w_elem > CLAMP_MAX) begin
            w_read = CLAMP_MAX;
        end else begin
            w_read = w_elem;
        end
    end
`else
    assign w_read = w_elem;
`endif

    // Outputs are forced to zero outside STREAM so reset clears them at once.
    assign out_if.out_data  = w_streaming ? w_read : '0;
    assign out_if.out_valid = w_streaming;
    assign out_if.out_row   = r_row;
    assign out_if.out_col   = r_col;
    assign out_if.out_last  = w_streaming & w_at_last;
    assign busy             = w_streaming;
    assign frame_done       = r_frame_done;
    assign overrun          = r_overrun;

endmodule
